imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 108 ++++++++++
 tb/tb_imem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Arbitrates per-core instruction fetches onto one synchronous single-port IMEM with 1-cycle latency.
// Define IMEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority; otherwise round-robin.
module imem_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES-1:0]        flush,
  output logic [NUM_CORES-1:0]        req_ready,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PTR_W = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0] eff_req;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_id;
  logic                 pend_valid;
  logic [PTR_W-1:0]     pend_id;

  // A flushing core has already moved to a new PC, so its request does not compete.
  assign eff_req = req_valid & ~flush;

`ifdef IMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (eff_req[i]) begin
        grant_any = 1'b1;
        grant_id  = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] cand;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_CORES) sum = sum - NUM_CORES;
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!grant_any && eff_req[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= wrap_add(grant_id, 1);
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    mem_en    = grant_any;
    mem_addr  = '0;
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
      mem_addr            = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    end
  end

  // The pending register tracks whose word arrives on mem_rdata next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_id    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      pend_valid <= grant_any;
      pend_id    <= grant_id;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (pend_valid && !flush[pend_id]) begin
      rsp_valid[pend_id] = 1'b1;
      rsp_data           = mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, reset-in-flight sequence,
// and randomized traffic against a behavioural model (honours IMEM_ARB_FIXED_PRIO_EN).
module tb_imem_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef IMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  flush;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  imem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  // Synchronous IMEM: data for the address strobed at an edge appears after that edge.
  always @(posedge clk) if (mem_en) mem_rdata <= mem_word(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; flush = '0; req_addr = '0;
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rsp_data", 64'(rsp_data), 64'h0);
    check("reset_req_ready", 64'(req_ready), 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  f;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  ready;
    logic [31:0] maddr;
    logic [1:0]  rv;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] f, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [1:0] ready,
                              input logic [31:0] maddr, input logic [1:0] rv, input logic [31:0] rd);
    vec_t r;
    r.v = v; r.f = f; r.a0 = a0; r.a1 = a1; r.ready = ready; r.maddr = maddr; r.rv = rv; r.rd = rd;
    return r;
  endfunction

  vec_t tbl[15];

  // Behavioural model state for the random phase.
  int            m_ptr;
  bit            m_pv;
  int            m_pid;
  logic [AW-1:0] m_paddr;
  logic [AW-1:0] addr_q[N];
  logic [N-1:0]  v_q;

  initial begin
    // Consecutive cycles from reset: single fetch, back-to-back, contention, flush, flush+request.
    tbl[0]  = mk(2'b01, 2'b00, 32'h0,   32'h0,   2'b01, 32'h0,   2'b00, 32'h0);
    tbl[1]  = mk(2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 32'h0,   2'b01, 32'h0050_0093);
    tbl[2]  = mk(2'b10, 2'b00, 32'h0,   32'h4,   2'b10, 32'h4,   2'b00, 32'h0);
    tbl[3]  = mk(2'b10, 2'b00, 32'h0,   32'h8,   2'b10, 32'h8,   2'b10, 32'h0050_0097);
    tbl[4]  = mk(2'b10, 2'b00, 32'h0,   32'hC,   2'b10, 32'hC,   2'b10, 32'h0050_009B);
    tbl[5]  = mk(2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 32'h0,   2'b10, 32'h0050_009F);
    tbl[6]  = mk(2'b11, 2'b00, 32'h100, 32'h200, 2'b01, 32'h100, 2'b00, 32'h0);
    if (!FIXED) begin
      tbl[7]  = mk(2'b11, 2'b00, 32'h100, 32'h200, 2'b10, 32'h200, 2'b01, 32'h0050_0193);
      tbl[8]  = mk(2'b11, 2'b00, 32'h100, 32'h200, 2'b01, 32'h100, 2'b10, 32'h0050_0293);
      tbl[9]  = mk(2'b11, 2'b00, 32'h100, 32'h200, 2'b10, 32'h200, 2'b01, 32'h0050_0193);
      tbl[10] = mk(2'b01, 2'b00, 32'h40,  32'h0,   2'b01, 32'h40,  2'b10, 32'h0050_0293);
    end else begin
      tbl[7]  = mk(2'b11, 2'b00, 32'h100, 32'h200, 2'b01, 32'h100, 2'b01, 32'h0050_0193);
      tbl[8]  = mk(2'b11, 2'b00, 32'h100, 32'h200, 2'b01, 32'h100, 2'b01, 32'h0050_0193);
      tbl[9]  = mk(2'b11, 2'b00, 32'h100, 32'h200, 2'b01, 32'h100, 2'b01, 32'h0050_0193);
      tbl[10] = mk(2'b01, 2'b00, 32'h40,  32'h0,   2'b01, 32'h40,  2'b01, 32'h0050_0193);
    end
    tbl[11] = mk(2'b10, 2'b01, 32'h0,   32'h44,  2'b10, 32'h44,  2'b00, 32'h0);
    tbl[12] = mk(2'b11, 2'b01, 32'h48,  32'h4C,  2'b10, 32'h4C,  2'b10, 32'h0050_00D7);
    tbl[13] = mk(2'b11, 2'b00, 32'h48,  32'h50,  2'b01, 32'h48,  2'b10, 32'h0050_00DF);
    tbl[14] = mk(2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 32'h0,   2'b01, 32'h0050_00DB);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      req_valid = tbl[i].v; flush = tbl[i].f; req_addr = {tbl[i].a1, tbl[i].a0};
      #3;
      check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].ready));
      check($sformatf("vec%0d_mem_en", i), 64'(mem_en), 64'(tbl[i].ready != 2'b00));
      check($sformatf("vec%0d_mem_addr", i), 64'(mem_addr), 64'(tbl[i].maddr));
      check($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].rv));
      check($sformatf("vec%0d_rsp_data", i), 64'(rsp_data), 64'(tbl[i].rd));
      @(posedge clk); #1;
    end

    // Reset lands while core0's word is in flight; rr_ptr must return to 0.
    do_reset();
    req_valid = 2'b01; req_addr = {32'h0, 32'h10};
    #3 check("rst_fl_grant", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    check("rst_fl_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_fl_rsp_data", 64'(rsp_data), 64'h0);
    req_valid = 2'b10; req_addr = {32'h20, 32'h0};
    #1;
    check("rst_comb_ready", 64'(req_ready), 64'h2);
    check("rst_comb_mem_addr", 64'(mem_addr), 64'h20);
    req_valid = 2'b00;
    @(posedge clk); #2 rst_n = 1'b1;
    #1 check("rst_after_rsp_valid", 64'(rsp_valid), 64'h0);
    @(posedge clk); #1;
    check("rst_after_rsp_valid2", 64'(rsp_valid), 64'h0);
    req_valid = 2'b11; req_addr = {32'h34, 32'h30};
    #3 check("rst_ptr_zero", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #3;
    check("rst_next_rsp_valid", 64'(rsp_valid), 64'h1);
    check("rst_next_rsp_data", 64'(rsp_data), 64'h0050_00A3);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    do_reset();
    m_ptr = 0; m_pv = 1'b0; m_pid = 0; m_paddr = '0;
    v_q = '0;
    for (int i = 0; i < N; i++) addr_q[i] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [N-1:0] f;
      logic [N-1:0] eff;
      int win, best, d;
      logic [N-1:0] exp_rv;
      logic [DW-1:0] exp_rd;
      f = '0;
      for (int i = 0; i < N; i++) begin
        f[i] = ($urandom_range(7) == 0);
        if (!v_q[i] || f[i]) begin
          v_q[i]    = ($urandom_range(1) == 1);
          addr_q[i] = {$urandom_range(32'hFFFF), 2'b00};
        end
        req_addr[i*AW +: AW] = addr_q[i];
      end
      req_valid = v_q; flush = f;
      eff = v_q & ~f;
      win = -1; best = N;
      for (int i = 0; i < N; i++) begin
        if (eff[i]) begin
          d = FIXED ? i : (i - m_ptr + N) % N;
          if (d < best) begin best = d; win = i; end
        end
      end
      exp_rv = '0; exp_rd = '0;
      if (m_pv && !f[m_pid]) begin
        exp_rv[m_pid] = 1'b1;
        exp_rd = mem_word(m_paddr);
      end
      #3;
      check("rnd_req_ready", 64'(req_ready), (win >= 0) ? (64'h1 << win) : 64'h0);
      check("rnd_mem_en", 64'(mem_en), 64'(win >= 0));
      check("rnd_mem_addr", 64'(mem_addr), (win >= 0) ? 64'(addr_q[win]) : 64'h0);
      check("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("rnd_rsp_data", 64'(rsp_data), 64'(exp_rd));
      @(posedge clk); #1;
      m_pv = (win >= 0);
      if (win >= 0) begin
        m_pid   = win;
        m_paddr = addr_q[win];
        m_ptr   = (win + 1) % N;
        v_q[win] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
